alu_seq_responder: RTL
======================

// Module: alu_seq_responder
// PURPOSE
//  Multi-cycle, slice-serial ALU behind a valid/ready request/response interface;
//  the responder to the ALU stimulus/checker initiator. Accepts (a, b, op) and
//  returns (z, ex) after WIDTH/SLICE cycles.
//  Same op encoding and results as the combinational yAlu, so one checker serves both.
// PARAMETERS
//  WIDTH  32  operand/result width
//  SLICE   8  bits processed per BUSY cycle; WIDTH % SLICE == 0; NSL = WIDTH/SLICE
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  req_valid  in   1      request present
//  req_ready  out  1      responder can accept request
//  req_a      in   WIDTH  operand a (signed for slt)
//  req_b      in   WIDTH  operand b (signed for slt)
//  req_op     in   3      000 and, 001 or, 010 add, 110 sub, 111 slt
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer takes response
//  z          out  WIDTH  result
//  ex         out  1      zero flag: 1 iff z == 0
//  bad_op     out  1      op was not one of the five legal codes
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=1, rsp_valid=0, z=0, ex=0, bad_op=0,
//   slice counter=0, carry=0; operand registers cleared.
//  States:
//   IDLE: req_ready=1. On req_valid&&req_ready: latch a, b, op; carry=1 if op in {110,111}
//    (b inverted for sub/slt), else 0; cnt=0 -> BUSY.
//   BUSY: req_ready=0. Each edge processes slice cnt (bits cnt*SLICE +: SLICE):
//    and/or bitwise; add/sub/slt SLICE-bit add with registered carry-in/out;
//    cnt++. Edge with cnt==NSL-1 -> DONE.
//   DONE: rsp_valid=1, req_ready=0; z/ex/bad_op stable. On rsp_valid&&rsp_ready -> IDLE.
//  Latency: accept on edge N -> rsp_valid high after edge N+NSL (NSL=4 by default).
//  No back-to-back overlap: next request accepted earliest on the edge after handshake.
//  slt: lt = diff[WIDTH-1] ^ ovf, ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
//   z = {0..., lt}. Resolved on the final BUSY edge.
//  add/sub wrap modulo 2^WIDTH; overflow not reported.
//  Illegal op: no slice work; z=0, ex=1, bad_op=1; same NSL latency.
//  bad_op=0 on every legal op; ex=(z==0) for all ops.
//  req_* are ignored outside IDLE and need not be held after acceptance.
//  rsp_ready outside DONE has no effect.
//  rst asserted in any state (incl. mid-BUSY): work is discarded immediately;
//   no partial response is ever emitted.
// TESTING
//  and: a=F0F0F0F0 b=0FF00FF0 -> z=00F000F0, ex=0, rsp_valid 4 cycles after accept.
//  or:  a=F0F0F0F0 b=0FF00FF0 -> z=FFF0FFF0, ex=0.
//  add: a=7FFFFFFF b=00000001 -> z=80000000 (carry crosses slices), ex=0.
//  add: a=FFFFFFFF b=00000001 -> z=00000000, ex=1.
//  sub: a=5 b=5 -> z=0, ex=1.
//  slt: a=FFFFFFFF b=1 -> z=1; a=80000000 b=7FFFFFFF -> z=1 (overflow);
//   a=7FFFFFFF b=80000000 -> z=0, ex=1.
//  illegal op=011 -> z=0, ex=1, bad_op=1; next legal op clears bad_op.
//  Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid=1, z stable,
//   req_ready=0, new req_valid ignored; then rsp_ready=1 -> IDLE the next cycle.
//  Reset at 2nd BUSY cycle -> rsp_valid=0, req_ready=1 immediately;
//   a following add 3+4 returns z=7.
//  Random: 1000 ops over the 5 legal codes vs. a reference model;
//   rsp_valid exactly 4 cycles after each accept.

Source files
------------

// File: rtl/alu_seq_responder.sv
// Slice-serial ALU responder: accepts (a, b, op) over valid/ready, processes SLICE bits
// per cycle and returns (z, ex, bad_op) NSL cycles after acceptance.
module alu_seq_responder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] z,
    output logic             ex,
    output logic             bad_op
);
    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                        state_q, state_d;
    logic [WIDTH-1:0]              a_q, a_d;
    logic [WIDTH-1:0]              b_q, b_d;
    logic [2:0]                    op_q, op_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          carry_q, carry_d;
    logic [NSL-1:0][SLICE-1:0]     res_q, res_d;
    logic [WIDTH-1:0]              z_q, z_d;
    logic                          ex_q, ex_d;
    logic                          bad_q, bad_d;

    logic [SLICE-1:0] a_sl [NSL];
    logic [SLICE-1:0] b_sl [NSL];
    logic [SLICE-1:0] sa, sb, slice_res;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] merged;
    logic             legal, ovf, lt;

    // Full-width view of the result with the slice being finished this cycle spliced in.
    generate
        for (genvar gi = 0; gi < NSL; gi++) begin : g_slice
            assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
            assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
            assign merged[gi*SLICE +: SLICE] = (cnt_q == CW'(gi)) ? slice_res : res_q[gi];
        end
    endgenerate

    assign sa    = a_sl[cnt_q];
    assign sb    = b_sl[cnt_q];
    assign sum   = {1'b0, sa} + {1'b0, sb} + {{SLICE{1'b0}}, carry_q};
    assign legal = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ADD) ||
                   (op_q == OP_SUB) || (op_q == OP_SLT);

    always_comb begin
        case (op_q)
            OP_AND:  slice_res = sa & sb;
            OP_OR:   slice_res = sa | sb;
            default: slice_res = sum[SLICE-1:0];
        endcase
    end

    // b_q holds ~b for slt, so the original signs differ exactly when a and b_q MSBs match.
    assign ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);
    assign lt  = merged[WIDTH-1] ^ ovf;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        z_d     = z_q;
        ex_d    = ex_q;
        bad_d   = bad_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    op_d    = req_op;
                    carry_d = (req_op == OP_SUB) || (req_op == OP_SLT);
                    b_d     = carry_d ? ~req_b : req_b;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (legal) begin
                    res_d[cnt_q] = slice_res;
                    carry_d      = sum[SLICE];
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NSL - 1)) begin
                    state_d = DONE;
                    if (!legal) begin
                        z_d = '0;
                    end else if (op_q == OP_SLT) begin
                        z_d = {{(WIDTH-1){1'b0}}, lt};
                    end else begin
                        z_d = merged;
                    end
                    ex_d  = (z_d == '0);
                    bad_d = !legal;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            z_q     <= '0;
            ex_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            z_q     <= z_d;
            ex_q    <= ex_d;
            bad_q   <= bad_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign z         = z_q;
    assign ex        = ex_q;
    assign bad_op    = bad_q;
endmodule
